// File: rtl/matrix_seq_if.sv
// matrix_seq_if: command, memory-port, ALU and status signals of the matrix sequencer.
// The sequencer itself uses the slave view; the front end / environment uses master.
interface matrix_seq_if #(
  parameter int ELEM_W = 16,
  parameter int ELEMS  = 16,
  parameter int ADDR_W = 12
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [3:0]              cmd_op;
  logic [ADDR_W-1:0]       cmd_src_a;
  logic [ADDR_W-1:0]       cmd_src_b;
  logic [ADDR_W-1:0]       cmd_dst;
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [ELEM_W-1:0]       mem_wdata;
  logic [ELEM_W-1:0]       mem_rdata;
  logic [ELEMS*ELEM_W-1:0] alu_matrixa;
  logic [ELEMS*ELEM_W-1:0] alu_matrixb;
  logic [3:0]              alu_op;
  logic [ELEMS*ELEM_W-1:0] alu_matrixc;
  logic                    busy;
  logic                    done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, mem_rdata, alu_matrixc,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
           alu_matrixa, alu_matrixb, alu_op, busy, done
  );

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, mem_rdata, alu_matrixc,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
           alu_matrixa, alu_matrixb, alu_op, busy, done
  );
endinterface

// File: rtl/matrix_seq.sv
// matrix_seq: command sequencer for the matrix ALU. Loads operand matrices A and B
// word by word from local memory, presents them to the ALU, captures the result and
// stores it back. Sole owner of the operand/result memory port.
// Optional feature macro: MATRIX_SEQ_FWD_EN -- when defined, the last result is kept
// and a command whose src_a equals the previous dst skips loading A.
module matrix_seq #(
  parameter int ELEM_W  = 16,
  parameter int ELEMS   = 16,
  parameter int ADDR_W  = 12,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  matrix_seq_if.slave  bus
);
  localparam int IDX_W = $clog2(ELEMS);
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(ELEMS - 1);
  localparam logic [CNT_W-1:0] LAST_EXEC = CNT_W'(ALU_LAT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    STORE,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [CNT_W-1:0]             cnt;
  logic [IDX_W-1:0]             idx;
  logic [ADDR_W-1:0]            src_a_q;
  logic [ADDR_W-1:0]            src_b_q;
  logic [ADDR_W-1:0]            dst_q;
  logic [ELEMS-1:0][ELEM_W-1:0] mata;
  logic [ELEMS-1:0][ELEM_W-1:0] matb;
  logic [ELEMS-1:0][ELEM_W-1:0] result;
  logic [3:0]                   alu_op_q;
  logic                         pend;
  logic                         pend_b;
  logic [IDX_W-1:0]             pend_idx;
  logic                         cmd_ready;
  logic                         accept;
  logic                         fwd_hit;
  logic                         mem_req;
  logic                         mem_we;
  logic [ADDR_W-1:0]            mem_addr;
  logic [ELEM_W-1:0]            mem_wdata;

  assign idx       = cnt[IDX_W-1:0];
  assign cmd_ready = (state == IDLE) && rst;
  assign accept    = bus.cmd_valid && cmd_ready;

  assign bus.cmd_ready   = cmd_ready;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.alu_matrixa = mata;
  assign bus.alu_matrixb = matb;
  assign bus.alu_op      = alu_op_q;
  assign bus.busy        = (state != IDLE) && (state != DONE);
  assign bus.done        = (state == DONE);

`ifdef MATRIX_SEQ_FWD_EN
  logic              fwd_valid;
  logic [ADDR_W-1:0] fwd_dst;

  assign fwd_hit = fwd_valid && (bus.cmd_src_a == fwd_dst) && (bus.cmd_op != 4'h0);

  // Remember where the last completed result went; a NOP invalidates it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_valid <= 1'b0;
      fwd_dst   <= '0;
    end else if (accept && (bus.cmd_op == 4'h0)) begin
      fwd_valid <= 1'b0;
    end else if ((state == STORE) && (state_n == DONE)) begin
      fwd_valid <= 1'b1;
      fwd_dst   <= dst_q;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  // State register; reset aborts any command in flight immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and memory-port drive; memory outputs are idle outside LOAD/STORE
  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_op == 4'h0) begin
            state_n = DONE;
          end else if (fwd_hit) begin
            state_n = LOAD_B;
          end else begin
            state_n = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        mem_req  = 1'b1;
        mem_addr = src_a_q + ADDR_W'(cnt);
        if (cnt == LAST_ELEM) begin
          state_n = LOAD_B;
        end
      end
      LOAD_B: begin
        mem_req  = 1'b1;
        mem_addr = src_b_q + ADDR_W'(cnt);
        if (cnt == LAST_ELEM) begin
          state_n = EXEC;
        end
      end
      EXEC: begin
        if (cnt == LAST_EXEC) begin
          state_n = STORE;
        end
      end
      STORE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_q + ADDR_W'(cnt);
        mem_wdata = result[idx];
        if (cnt == LAST_ELEM) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Per-state beat counter, restarted on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state_n != state) begin
      cnt <= '0;
    end else if (state != IDLE) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Command latch, operand capture one cycle behind each read, and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_a_q  <= '0;
      src_b_q  <= '0;
      dst_q    <= '0;
      alu_op_q <= '0;
      mata     <= '0;
      matb     <= '0;
      result   <= '0;
      pend     <= 1'b0;
      pend_b   <= 1'b0;
      pend_idx <= '0;
    end else begin
      pend <= 1'b0;
      if (accept) begin
        src_a_q <= bus.cmd_src_a;
        src_b_q <= bus.cmd_src_b;
        dst_q   <= bus.cmd_dst;
        if (bus.cmd_op != 4'h0) begin
          alu_op_q <= bus.cmd_op;
        end
        if (fwd_hit) begin
          mata <= result;
        end
      end
      if ((state == LOAD_A) || (state == LOAD_B)) begin
        pend     <= 1'b1;
        pend_b   <= (state == LOAD_B);
        pend_idx <= idx;
      end
      if (pend) begin
        if (pend_b) begin
          matb[pend_idx] <= bus.mem_rdata;
        end else begin
          mata[pend_idx] <= bus.mem_rdata;
        end
      end
      if ((state == EXEC) && (cnt == LAST_EXEC)) begin
        result <= bus.alu_matrixc;
      end
    end
  end
endmodule

// File: tb/tb_matrix_seq.sv
// tb_matrix_seq: directed-vector bench for matrix_seq with a queue scoreboard.
// Stimulus pushes expected reads, writes and done cycles; a negedge monitor pops
// and compares whenever the sequencer drives the memory port or pulses done.
module tb_matrix_seq;
  localparam int ELEM_W = 16;
  localparam int ELEMS  = 16;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cycle = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic [15:0] mem    [0:4095];
  logic [15:0] refmem [0:4095];

  int          rdQ[$];
  logic [27:0] wrQ[$];
  int          doneQ[$];

  bit fwdValid = 1'b0;
  int fwdDst = 0;

  always #5 clk = ~clk;

  matrix_seq_if #(.ELEM_W(ELEM_W), .ELEMS(ELEMS), .ADDR_W(ADDR_W)) bus ();

  matrix_seq #(.ELEM_W(ELEM_W), .ELEMS(ELEMS), .ADDR_W(ADDR_W), .ALU_LAT(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] aluElem(logic [3:0] op, logic [15:0] a, logic [15:0] b);
    case (op)
      4'h4:    return a + b;
      4'hF:    return a ^ b;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk) cycle <= cycle + 1;

  // Word-wide memory: read data appears the cycle after the request
  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_we) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_req && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
  end

  // Combinational ALU: element-wise add or xor
  always_comb begin
    bus.alu_matrixc = '0;
    for (int i = 0; i < ELEMS; i++) begin
      bus.alu_matrixc[i*ELEM_W +: ELEM_W] = aluElem(bus.alu_op,
          bus.alu_matrixa[i*ELEM_W +: ELEM_W], bus.alu_matrixb[i*ELEM_W +: ELEM_W]);
    end
  end

  task automatic checkOutput(string name, logic [255:0] actual, logic [255:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportUnexpected(string name, logic [255:0] actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got 0x%0h, expected no event", name, actual);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (bus.mem_req && !bus.mem_we) begin
      if (rdQ.size() == 0) reportUnexpected("unexpected read", 256'(bus.mem_addr));
      else checkOutput("read addr", 256'(bus.mem_addr), 256'(rdQ.pop_front()));
    end
    if (bus.mem_req && bus.mem_we) begin
      if (wrQ.size() == 0) reportUnexpected("unexpected write", 256'({bus.mem_addr, bus.mem_wdata}));
      else checkOutput("write addr/data", 256'({bus.mem_addr, bus.mem_wdata}), 256'(wrQ.pop_front()));
    end
    if (bus.done) begin
      if (doneQ.size() == 0) reportUnexpected("unexpected done", 256'(cycle));
      else checkOutput("done cycle", 256'(cycle), 256'(doneQ.pop_front()));
      checkOutput("busy at done", 256'(bus.busy), 256'(0));
    end
  end

  task automatic applyStimulus(input logic [3:0] op, input int srcA, input int srcB, input int dst,
                               input bit completes, input int nWrites, output int acceptCycle);
    logic [15:0] a [16];
    logic [15:0] b [16];
    logic [15:0] r [16];
    bit skipA;
    int lat;
    int n;
    skipA = 1'b0;
`ifdef MATRIX_SEQ_FWD_EN
    skipA = fwdValid && (srcA == fwdDst) && (op != 4'h0);
`endif
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.cmd_ready) reportUnexpected("cmd_ready timeout", 256'(n));
    lat = 1;
    if (op != 4'h0) begin
      for (int i = 0; i < 16; i++) begin
        a[i] = refmem[(srcA + i) % 4096];
        b[i] = refmem[(srcB + i) % 4096];
        r[i] = aluElem(op, a[i], b[i]);
      end
      if (!skipA) for (int i = 0; i < 16; i++) rdQ.push_back((srcA + i) % 4096);
      for (int i = 0; i < 16; i++) rdQ.push_back((srcB + i) % 4096);
      for (int i = 0; i < nWrites; i++) begin
        wrQ.push_back({12'((dst + i) % 4096), r[i]});
        refmem[(dst + i) % 4096] = r[i];
      end
      lat = skipA ? 35 : 51;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src_a = 12'(srcA);
    bus.cmd_src_b = 12'(srcB);
    bus.cmd_dst   = 12'(dst);
    acceptCycle   = cycle;
    if (completes) doneQ.push_back(cycle + lat);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'hF;
    bus.cmd_src_a = 12'hABC;
    bus.cmd_src_b = 12'hDEF;
    bus.cmd_dst   = 12'h777;
    if (op == 4'h0 || !completes) begin
      fwdValid = 1'b0;
    end else begin
      fwdValid = 1'b1;
      fwdDst   = dst;
    end
  endtask

  initial begin
    int t;
    int n;
    logic [255:0] expA;
    logic [255:0] expB;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 4'h0;
    bus.cmd_src_a = '0;
    bus.cmd_src_b = '0;
    bus.cmd_dst   = '0;
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = 16'(i) ^ 16'h5A00;
      refmem[i] = 16'(i) ^ 16'h5A00;
    end
    for (int i = 0; i < 16; i++) begin
      mem[i]             = 16'(i + 1);
      refmem[i]          = 16'(i + 1);
      mem[12'h100 + i]    = 16'd2;
      refmem[12'h100 + i] = 16'd2;
    end

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset mem_req", 256'(bus.mem_req), 256'(0));
    checkOutput("reset mem_we", 256'(bus.mem_we), 256'(0));
    checkOutput("reset busy", 256'(bus.busy), 256'(0));
    checkOutput("reset done", 256'(bus.done), 256'(0));
    checkOutput("reset mem_addr", 256'(bus.mem_addr), 256'(0));
    checkOutput("reset mem_wdata", 256'(bus.mem_wdata), 256'(0));
    checkOutput("reset alu_matrixa", bus.alu_matrixa, 256'(0));
    checkOutput("reset alu_matrixb", bus.alu_matrixb, 256'(0));
    checkOutput("reset alu_op", 256'(bus.alu_op), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("cmd_ready after reset", 256'(bus.cmd_ready), 256'(1));
    checkOutput("idle mem_req", 256'(bus.mem_req), 256'(0));

    // Add: A = 1..16, B = all 2, result 3..18 at 0x200
    applyStimulus(4'h4, 12'h000, 12'h100, 12'h200, 1'b1, 16, t);
    n = 0;
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 16; i++) begin
      expA[i*16 +: 16] = 16'(i + 1);
      expB[i*16 +: 16] = 16'd2;
    end
    checkOutput("add operand A", bus.alu_matrixa, expA);
    checkOutput("add operand B", bus.alu_matrixb, expB);

    // NOP: done next cycle, no traffic, opcode untouched
    applyStimulus(4'h0, 12'h123, 12'h456, 12'h789, 1'b1, 0, t);
    @(negedge clk);
    checkOutput("nop cmd_ready T+1", 256'(bus.cmd_ready), 256'(0));
    @(negedge clk);
    checkOutput("nop cmd_ready T+2", 256'(bus.cmd_ready), 256'(1));
    checkOutput("nop alu_op held", 256'(bus.alu_op), 256'(4));

    // Address wrap on reads and writes, xor op
    applyStimulus(4'hF, 12'hFFA, 12'h100, 12'hFF8, 1'b1, 16, t);

    // Reset during the fifth store write
    applyStimulus(4'h4, 12'h020, 12'h100, 12'h400, 1'b0, 4, t);
    repeat (38) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort mem_req", 256'(bus.mem_req), 256'(0));
    checkOutput("abort busy", 256'(bus.busy), 256'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Normal command after the abort
    applyStimulus(4'h4, 12'h000, 12'h100, 12'h500, 1'b1, 16, t);

    // Back-to-back pair where the second source is the first destination
    applyStimulus(4'h4, 12'h000, 12'h100, 12'h300, 1'b1, 16, t);
    applyStimulus(4'h4, 12'h300, 12'h100, 12'h310, 1'b1, 16, t);

    n = 0;
    while ((rdQ.size() != 0 || wrQ.size() != 0 || doneQ.size() != 0 || !bus.cmd_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reads outstanding", 256'(rdQ.size()), 256'(0));
    checkOutput("writes outstanding", 256'(wrQ.size()), 256'(0));
    checkOutput("dones outstanding", 256'(doneQ.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
